xl_rect_fill: RTL and testbench
===============================

Name: xl_rect_fill

Overview:
- Hardware accelerator (XL) fill engine that sits directly upstream of the frame-buffer write arbiter.
- Accepts a rectangle command (two corners plus colour) from CPU-side MMIO logic.
- Emits one frame-buffer write per cycle on its XL write port until every pixel in the rectangle is written.
- The arbiter gives XL writes priority, so this engine never stalls.

Parameters:
- FB_WIDTH, 1024, frame width in pixels (one pixel per memory word).
- FB_HEIGHT, 768, frame height in pixels.
- PIXEL_WIDTH, 32, bits per pixel; equals the frame-buffer word width.
- ADDR_WIDTH, 20, frame-buffer word address width; must cover FB_WIDTH*FB_HEIGHT.
- COORD_WIDTH, 11, width of each x/y coordinate input.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- x0  input  COORD_WIDTH  first corner, x.
- y0  input  COORD_WIDTH  first corner, y.
- x1  input  COORD_WIDTH  second corner, x.
- y1  input  COORD_WIDTH  second corner, y.
- color  input  PIXEL_WIDTH  fill value.
- busy  output  1  high from command acceptance through the last write.
- done  output  1  one-cycle pulse after the last write.
- XL_wr_en  output  1  frame write strobe, feeds the arbiter.
- XL_wr_addr  output  ADDR_WIDTH  write address, y*FB_WIDTH + x.
- XL_wr_data  output  PIXEL_WIDTH  write data, the latched colour.

Behaviour:
- Reset:
  - rst_n low forces state IDLE immediately, independent of clk.
  - busy, done, XL_wr_en, XL_wr_addr and XL_wr_data all go to 0.
  - Reset mid-fill abandons the rectangle; no further writes are issued after rst_n rises.
- All outputs are registered.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE:
  - On a clk edge with start=1, latch color and the normalised corners: xl=min(x0,x1), xr=max, yt=min(y0,y1), yb=max.
  - Set busy=1 and go to SETUP.
  - start=0 means stay in IDLE.
- SETUP (one cycle):
  - row_base = yt*FB_WIDTH, truncated to ADDR_WIDTH.
  - Cursor x=xl, y=yt. Go to FILL.
- FILL:
  - Each cycle registers XL_wr_en=1, XL_wr_addr=row_base+x (mod 2^ADDR_WIDTH) and XL_wr_data=colour.
  - x<xr: x increments.
  - x==xr and y<yb: x=xl, y increments, row_base+=FB_WIDTH.
  - x==xr and y==yb: go to DONE.
- Latency:
  - start accepted at edge N.
  - First write strobe is visible after edge N+2.
  - Exactly (xr-xl+1)*(yb-yt+1) consecutive write cycles, with no gaps.
- DONE (one cycle):
  - XL_wr_en=0, busy=0, done=1.
  - Next edge: done=0, state IDLE.
  - A new start is accepted no earlier than the edge after the done cycle.
- start while busy is ignored; the command inputs are not re-latched.
- Degenerate rectangles:
  - x0==x1 and/or y0==y1 are legal.
  - A single pixel gives exactly one write.
- Write-port hold rule: XL_wr_addr and XL_wr_data hold their last values when XL_wr_en=0. Only XL_wr_en is qualifying.

Optional Feature:
- Macro: XL_FILL_CLIP_EN.
- Defined:
  - After normalisation in IDLE, xr is clamped to FB_WIDTH-1 and yb to FB_HEIGHT-1.
  - If xl>FB_WIDTH-1 or yt>FB_HEIGHT-1, no writes are issued: SETUP goes straight to DONE and done still pulses.
- Undefined:
  - Coordinates are used unchecked.
  - Out-of-range pixels produce addresses computed mod 2^ADDR_WIDTH, which may alias visible memory.
  - Write count is always the full rectangle area.

Test Plan:
- Reset values: assert rst_n=0 mid-clock -> all outputs 0 immediately; after release, idle with XL_wr_en=0 indefinitely.
- Single pixel:
  - Stimulus: start, x0=x1=5, y0=y1=2, color=0xFF00FF00.
  - Required: exactly one write at addr 2053, data 0xFF00FF00, two cycles after the start edge.
  - Required: done pulses the next cycle.
- Swapped corners:
  - Stimulus: x0=3, x1=1, y0=1, y1=0.
  - Required: 6 writes in order 1,2,3,1025,1026,1027, no gaps.
  - Required: busy high for 8 cycles, then done.
- Start while busy: assert start again mid-fill with different coordinates -> ignored; write count and addresses match the first command only.
- Reset mid-fill: start a 10x10 fill and drop rst_n after 37 writes -> XL_wr_en=0 at once; no writes after release until a new start.
- Clip, with XL_FILL_CLIP_EN:
  - Stimulus: x0=1022, x1=1030, y0=y1=767.
  - Required: 2 writes at 786430 and 786431.
  - Stimulus: x0=1100, x1=1200, y0=y1=0.
  - Required: 0 writes, done still pulses.

Source files
------------

// File: rtl/xl_rect_fill.sv
// xl_rect_fill: rectangle fill engine for the XL frame-buffer write port.
// Latches a normalised rectangle and colour, then issues one write per cycle,
// row by row, until the rectangle is covered. All outputs are registered.
// Optional build macro XL_FILL_CLIP_EN clamps the rectangle to the visible
// frame and skips rectangles that start off-screen.
module xl_rect_fill #(
  parameter int unsigned FB_WIDTH    = 1024,
  parameter int unsigned FB_HEIGHT   = 768,
  parameter int unsigned PIXEL_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned COORD_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y1,
  input  logic [PIXEL_WIDTH-1:0] color,
  output logic                   busy,
  output logic                   done,
  output logic                   XL_wr_en,
  output logic [ADDR_WIDTH-1:0]  XL_wr_addr,
  output logic [PIXEL_WIDTH-1:0] XL_wr_data
);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] FbWidthA = ADDR_WIDTH'(FB_WIDTH);

  // Elaboration-time guard: the address must reach every visible pixel.
  if (ADDR_WIDTH < $clog2(FB_WIDTH * FB_HEIGHT)) begin : g_addr_check
    $error("xl_rect_fill: ADDR_WIDTH too narrow for FB_WIDTH*FB_HEIGHT");
  end

  state_e                 state_q, state_d;
  logic [COORD_WIDTH-1:0] xl_q, xl_d, xr_q, xr_d, yt_q, yt_d, yb_q, yb_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
  logic [PIXEL_WIDTH-1:0] color_q, color_d;
  logic                   busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [COORD_WIDTH-1:0] xl_n, xr_n, yt_n, yb_n, xr_lim, yb_lim;
  logic                   skip, last_px;

  // Normalise the corners so xl<=xr and yt<=yb.
  always_comb begin
    xl_n = (x0 < x1) ? x0 : x1;
    xr_n = (x0 < x1) ? x1 : x0;
    yt_n = (y0 < y1) ? y0 : y1;
    yb_n = (y0 < y1) ? y1 : y0;
  end

`ifdef XL_FILL_CLIP_EN
  localparam logic [COORD_WIDTH-1:0] XMax = COORD_WIDTH'(FB_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YMax = COORD_WIDTH'(FB_HEIGHT - 1);

  assign xr_lim = (xr_n > XMax) ? XMax : xr_n;
  assign yb_lim = (yb_n > YMax) ? YMax : yb_n;
  // Rectangle entirely off-screen: no pixel survives the clamp.
  assign skip   = (xl_q > XMax) || (yt_q > YMax);
`else
  assign xr_lim = xr_n;
  assign yb_lim = yb_n;
  assign skip   = 1'b0;
`endif

  assign last_px = (x_q == xr_q) && (y_q == yb_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: state_d = skip ? StDone : StFill;
      StFill:  if (last_px) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values; write port holds when idle.
  always_comb begin
    xl_d       = xl_q;
    xr_d       = xr_q;
    yt_d       = yt_q;
    yb_d       = yb_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    color_d    = color_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xl_d    = xl_n;
          xr_d    = xr_lim;
          yt_d    = yt_n;
          yb_d    = yb_lim;
          color_d = color;
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        row_base_d = ADDR_WIDTH'(yt_q) * FbWidthA;
        x_d        = xl_q;
        y_d        = yt_q;
      end
      StFill: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base_q + ADDR_WIDTH'(x_q);
        wr_data_d = color_q;
        if (x_q != xr_q) begin
          x_d = x_q + COORD_WIDTH'(1);
        end else if (y_q != yb_q) begin
          x_d        = xl_q;
          y_d        = y_q + COORD_WIDTH'(1);
          row_base_d = row_base_q + FbWidthA;
        end
      end
      StDone: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xl_q       <= '0;
      xr_q       <= '0;
      yt_q       <= '0;
      yb_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      color_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      xl_q       <= xl_d;
      xr_q       <= xr_d;
      yt_q       <= yt_d;
      yb_q       <= yb_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign XL_wr_en   = wr_en_q;
  assign XL_wr_addr = wr_addr_q;
  assign XL_wr_data = wr_data_q;

endmodule

// File: tb/tb_xl_rect_fill.sv
// Directed self-checking bench for xl_rect_fill (default 1024x768 geometry).
module tb_xl_rect_fill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] x0, y0, x1, y1;
  logic [31:0] color;
  logic        busy, done, XL_wr_en;
  logic [19:0] XL_wr_addr;
  logic [31:0] XL_wr_data;

  int checks   = 0;
  int failures = 0;

  int unsigned wr_addrs[$];
  logic [31:0] wr_datas[$];

  xl_rect_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .color      (color),
    .busy       (busy),
    .done       (done),
    .XL_wr_en   (XL_wr_en),
    .XL_wr_addr (XL_wr_addr),
    .XL_wr_data (XL_wr_data)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (XL_wr_en === 1'b1) begin
      wr_addrs.push_back(int'(XL_wr_addr));
      wr_datas.push_back(XL_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c,
                       input logic [10:0] d, input logic [31:0] col);
    @(negedge clk);
    x0 = a; y0 = b; x1 = c; y1 = d; color = col; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_log();
    wr_addrs.delete();
    wr_datas.delete();
  endtask

  initial begin
    int busy_cnt, done_at, first_wr, last_wr, nwr, bad;
    bit found;
    int unsigned exp_sw[6];
    exp_sw = '{1, 2, 3, 1025, 1026, 1027};

    // Reset asserted away from any clock edge.
    rst_n = 1'b0; start = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    #1;
    chk("rst_outputs", {busy, done, XL_wr_en, XL_wr_addr, XL_wr_data}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (XL_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_after_rst", bad, 0);
    clear_log();

    // Single pixel: write visible after edge N+2, done after N+3.
    @(negedge clk);
    x0 = 11'd5; x1 = 11'd5; y0 = 11'd2; y1 = 11'd2; color = 32'hFF00FF00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sp_busy_n", {busy, XL_wr_en}, 2'b10);
    @(negedge clk);
    chk("sp_nowr_n1", XL_wr_en, 1'b0);
    @(negedge clk);
    chk("sp_wr", {XL_wr_en, XL_wr_addr, XL_wr_data}, {1'b1, 20'd2053, 32'hFF00FF00});
    @(negedge clk);
    chk("sp_done", {XL_wr_en, busy, done}, 3'b001);
    chk("sp_hold", {XL_wr_addr, XL_wr_data}, {20'd2053, 32'hFF00FF00});
    @(negedge clk);
    chk("sp_done_clr", done, 1'b0);
    chk("sp_count", wr_addrs.size(), 1);
    clear_log();

    // Swapped corners: 3x2 rectangle, busy 8 cycles, writes at cycles 3..8.
    @(negedge clk);
    x0 = 11'd3; x1 = 11'd1; y0 = 11'd1; y1 = 11'd0; color = 32'h12345678; start = 1'b1;
    busy_cnt = 0; done_at = -1; first_wr = -1; last_wr = -1; nwr = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at < 0) done_at = i;
      if (XL_wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = i;
        last_wr = i;
        nwr++;
      end
    end
    chk("sw_busy_cycles", busy_cnt, 8);
    chk("sw_done_at", done_at, 9);
    chk("sw_span", {first_wr[7:0], last_wr[7:0], nwr[7:0]}, {8'd3, 8'd8, 8'd6});
    chk("sw_count", wr_addrs.size(), 6);
    for (int k = 0; k < 6 && k < wr_addrs.size(); k++) chk("sw_addr", wr_addrs[k], exp_sw[k]);
    chk("sw_hold", {XL_wr_addr, XL_wr_data}, {20'd1027, 32'h12345678});
    clear_log();

    // Start while busy: second command must be ignored.
    issue(11'd10, 11'd4, 11'd13, 11'd6, 32'hA5A5_0001);
    repeat (2) @(negedge clk);
    x0 = 11'd0; y0 = 11'd0; x1 = 11'd0; y1 = 11'd0; color = 32'h5A5A_0002; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(40, found);
    chk("sb_done", found, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_count", wr_addrs.size(), 12);
    if (wr_addrs.size() == 12) begin
      chk("sb_first", wr_addrs[0], 4106);
      chk("sb_last", wr_addrs[11], 6157);
    end
    bad = 0;
    foreach (wr_datas[k]) if (wr_datas[k] !== 32'hA5A5_0001) bad++;
    chk("sb_data", bad, 0);
    clear_log();

    // Reset after 37 writes of a 10x10 fill.
    issue(11'd0, 11'd0, 11'd9, 11'd9, 32'hCAFE_0003);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (wr_addrs.size() == 37) begin
        found = 1'b1;
        break;
      end
    end
    chk("rm_reach37", found, 1'b1);
    if (wr_addrs.size() == 37) chk("rm_addr37", wr_addrs[36], 3078);
    rst_n = 1'b0;
    #1;
    chk("rm_rst_now", {busy, done, XL_wr_en, XL_wr_addr, XL_wr_data}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    chk("rm_no_writes", wr_addrs.size(), 0);
    chk("rm_idle", busy, 1'b0);

    // New command after reset works normally.
    issue(11'd7, 11'd0, 11'd8, 11'd0, 32'h0000_0004);
    wait_done(10, found);
    chk("nr_done", found, 1'b1);
    chk("nr_count", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) chk("nr_first", wr_addrs[0], 7);
    clear_log();

    // Right/bottom edge and off-screen rectangles.
    issue(11'd1022, 11'd767, 11'd1030, 11'd767, 32'h0000_0005);
    wait_done(150, found);
    chk("edge_done", found, 1'b1);
    repeat (2) @(negedge clk);
`ifdef XL_FILL_CLIP_EN
    chk("clip_count", wr_addrs.size(), 2);
    if (wr_addrs.size() == 2) chk("clip_addrs", {wr_addrs[0], wr_addrs[1]}, {32'd786430, 32'd786431});
`else
    chk("noclip_count", wr_addrs.size(), 9);
    if (wr_addrs.size() == 9) chk("noclip_addrs", {wr_addrs[0], wr_addrs[8]}, {32'd786430, 32'd786438});
`endif
    clear_log();

    issue(11'd1100, 11'd0, 11'd1200, 11'd0, 32'h0000_0006);
    wait_done(150, found);
    chk("off_done", found, 1'b1);
    repeat (2) @(negedge clk);
`ifdef XL_FILL_CLIP_EN
    chk("clip_off_count", wr_addrs.size(), 0);
`else
    chk("noclip_off_count", wr_addrs.size(), 101);
    if (wr_addrs.size() == 101) chk("noclip_off_addrs", {wr_addrs[0], wr_addrs[100]}, {32'd1100, 32'd1200});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
